// File: rtl/wbu_pkg.sv
// Shared types and constants for the BLI201V32I write-back unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wbu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RA_W = 5;

  // Load funct3 encodings; anything else is treated as a full word.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Which producer owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EXU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_t;

  // Registered write stage, which is also the register-file write port.
  typedef struct packed {
    logic            w_en;
    logic [RA_W-1:0] rd_addr;
    logic [XLEN-1:0] rd_data;
  } wb_stage_t;

  // x0 is hard-wired zero, so it is never written nor tracked.
  function automatic logic rd_writes(input logic [RA_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/wbu_if.sv
// Bundle of EXU/LSU result, register-file port and IDU operand signals of the write-back unit.
// Latency: n/a (wiring only).
// Backpressure: EXU side sees wbu_o_exu_ready; LSU side is never stalled.
interface wbu_if;
  import wbu_pkg::*;

  logic            wbu_i_exu_valid;
  logic [RA_W-1:0] wbu_i_exu_rd_addr;
  logic [XLEN-1:0] wbu_i_exu_rd_data;
  logic            wbu_o_exu_ready;

  logic            wbu_i_lsu_issue;
  logic [RA_W-1:0] wbu_i_lsu_issue_rd_addr;
  logic            wbu_i_lsu_valid;
  logic [RA_W-1:0] wbu_i_lsu_rd_addr;
  logic [XLEN-1:0] wbu_i_lsu_rdata;
  logic [2:0]      wbu_i_lsu_funct3;
  logic [1:0]      wbu_i_lsu_byte_off;
  logic            wbu_o_lsu_ready;

  logic [RA_W-1:0] wbu_o_rd_addr;
  logic            wbu_o_w_en;
  logic [XLEN-1:0] wbu_o_rd_data;

  logic [RA_W-1:0] wbu_i_rs1_addr;
  logic [RA_W-1:0] wbu_i_rs2_addr;
  logic [XLEN-1:0] wbu_i_rs1_data;
  logic [XLEN-1:0] wbu_i_rs2_data;
  logic [XLEN-1:0] wbu_o_rs1_data;
  logic [XLEN-1:0] wbu_o_rs2_data;
  logic            wbu_o_rs1_busy;
  logic            wbu_o_rs2_busy;

  // Core side: drives results, issue info and operand reads.
  modport master (
    output wbu_i_exu_valid, wbu_i_exu_rd_addr, wbu_i_exu_rd_data,
    output wbu_i_lsu_issue, wbu_i_lsu_issue_rd_addr,
    output wbu_i_lsu_valid, wbu_i_lsu_rd_addr, wbu_i_lsu_rdata,
    output wbu_i_lsu_funct3, wbu_i_lsu_byte_off,
    output wbu_i_rs1_addr, wbu_i_rs2_addr, wbu_i_rs1_data, wbu_i_rs2_data,
    input  wbu_o_exu_ready, wbu_o_lsu_ready,
    input  wbu_o_rd_addr, wbu_o_w_en, wbu_o_rd_data,
    input  wbu_o_rs1_data, wbu_o_rs2_data, wbu_o_rs1_busy, wbu_o_rs2_busy
  );

  // Write-back unit side.
  modport slave (
    input  wbu_i_exu_valid, wbu_i_exu_rd_addr, wbu_i_exu_rd_data,
    input  wbu_i_lsu_issue, wbu_i_lsu_issue_rd_addr,
    input  wbu_i_lsu_valid, wbu_i_lsu_rd_addr, wbu_i_lsu_rdata,
    input  wbu_i_lsu_funct3, wbu_i_lsu_byte_off,
    input  wbu_i_rs1_addr, wbu_i_rs2_addr, wbu_i_rs1_data, wbu_i_rs2_data,
    output wbu_o_exu_ready, wbu_o_lsu_ready,
    output wbu_o_rd_addr, wbu_o_w_en, wbu_o_rd_data,
    output wbu_o_rs1_data, wbu_o_rs2_data, wbu_o_rs1_busy, wbu_o_rs2_busy
  );

endinterface

// File: rtl/wbu_load_align.sv
// Selects the byte/halfword of an aligned load word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
module wbu_load_align
  import wbu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane select followed by extension; unknown funct3 passes the word through.
  always_comb begin
    sel_byte = rdata[7:0];
    case (byte_off)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    // Halfword lane comes from bit 1 only; a misaligned LH is not trapped here.
    sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  data = {24'h0, sel_byte};
      F3_LH:   data = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  data = {16'h0, sel_half};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wbu.sv
// Write-back unit: arbitrates LSU/EXU results onto the register-file write port, tracks busy load targets, forwards operands.
// Latency: result accepted at edge N drives the write port from N to N+1; the file holds it after edge N+1.
// Backpressure: LSU always accepted; EXU stalled (wbu_o_exu_ready low) whenever LSU data returns. Option macro: BLI201V32I_WBU_BYPASS_EN.
module wbu
  import wbu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  wbu_if.slave  bus
);

  wb_src_t         src;
  wb_stage_t       acc;
  wb_stage_t       ws;
  logic [XLEN-1:0] lsu_fmt;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            rs1_hit;
  logic            rs2_hit;

  wbu_load_align u_load_align (
    .rdata    (bus.wbu_i_lsu_rdata),
    .funct3   (bus.wbu_i_lsu_funct3),
    .byte_off (bus.wbu_i_lsu_byte_off),
    .data     (lsu_fmt)
  );

  // Loads cannot be held off by the LSU, so they always win the port.
  assign bus.wbu_o_exu_ready = ~bus.wbu_i_lsu_valid;
  assign bus.wbu_o_lsu_ready = 1'b1;

  // Fixed-priority pick of the result entering the write stage.
  always_comb begin
    src = SRC_NONE;
    acc = '0;
    if (bus.wbu_i_lsu_valid) begin
      src         = SRC_LSU;
      acc.rd_addr = bus.wbu_i_lsu_rd_addr;
      acc.rd_data = lsu_fmt;
    end else if (bus.wbu_i_exu_valid) begin
      src         = SRC_EXU;
      acc.rd_addr = bus.wbu_i_exu_rd_addr;
      acc.rd_data = bus.wbu_i_exu_rd_data;
    end
    acc.w_en = (src != SRC_NONE) && rd_writes(acc.rd_addr);
  end

  // Write stage: load on accept, otherwise drop the enable and keep addr/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws <= '0;
    end else if (src != SRC_NONE) begin
      ws <= acc;
    end else begin
      ws.w_en <= 1'b0;
    end
  end

  assign bus.wbu_o_w_en    = ws.w_en;
  assign bus.wbu_o_rd_addr = ws.rd_addr;
  assign bus.wbu_o_rd_data = ws.rd_data;

  // Scoreboard update: clear on return, then set on issue so a same-cycle reissue stays busy.
  always_comb begin
    busy_nxt = busy;
    if (bus.wbu_i_lsu_valid) begin
      busy_nxt[bus.wbu_i_lsu_rd_addr] = 1'b0;
    end
    if (bus.wbu_i_lsu_issue && rd_writes(bus.wbu_i_lsu_issue_rd_addr)) begin
      busy_nxt[bus.wbu_i_lsu_issue_rd_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; outstanding loads are forgotten on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Operand hazards against the write stage, which the file has not absorbed yet.
  always_comb begin
    rs1_hit = ws.w_en && (ws.rd_addr == bus.wbu_i_rs1_addr) && rd_writes(bus.wbu_i_rs1_addr);
    rs2_hit = ws.w_en && (ws.rd_addr == bus.wbu_i_rs2_addr) && rd_writes(bus.wbu_i_rs2_addr);
`ifdef BLI201V32I_WBU_BYPASS_EN
    // Forward the in-flight value instead of stalling.
    bus.wbu_o_rs1_data = rs1_hit ? ws.rd_data : bus.wbu_i_rs1_data;
    bus.wbu_o_rs2_data = rs2_hit ? ws.rd_data : bus.wbu_i_rs2_data;
    bus.wbu_o_rs1_busy = busy[bus.wbu_i_rs1_addr];
    bus.wbu_o_rs2_busy = busy[bus.wbu_i_rs2_addr];
`else
    // No bypass: make the IDU wait one cycle until the file holds the value.
    bus.wbu_o_rs1_data = bus.wbu_i_rs1_data;
    bus.wbu_o_rs2_data = bus.wbu_i_rs2_data;
    bus.wbu_o_rs1_busy = busy[bus.wbu_i_rs1_addr] | rs1_hit;
    bus.wbu_o_rs2_busy = busy[bus.wbu_i_rs2_addr] | rs2_hit;
`endif
  end

  // At most one load in flight per register; a same-cycle return to that register frees it.
  a_no_waw_issue: assert property (@(posedge clk) disable iff (rst)
    (bus.wbu_i_lsu_issue && rd_writes(bus.wbu_i_lsu_issue_rd_addr) &&
     !(bus.wbu_i_lsu_valid && bus.wbu_i_lsu_rd_addr == bus.wbu_i_lsu_issue_rd_addr))
    |-> !busy[bus.wbu_i_lsu_issue_rd_addr]);

endmodule

// File: tb/tb_wbu.sv
// Testbench for wbu: directed cases plus randomized traffic against an architectural model.
// Latency: n/a.
// Backpressure: EXU results are held while wbu_o_exu_ready is low.
module tb_wbu;
  import wbu_pkg::*;

  logic clk;
  logic rst;
  wbu_if bus ();

  wbu dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef BLI201V32I_WBU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // stimulus for the current cycle
  logic        s_exu_v, s_iss, s_ret_v, exu_hold;
  logic [4:0]  s_exu_rd, s_iss_rd, s_ret_rd, s_rs1, s_rs2;
  logic [31:0] s_exu_d, s_ret_rdata;
  logic [2:0]  s_ret_f3;
  logic [1:0]  s_ret_off;

  // architectural model: latest value per register, file contents, in-flight loads
  logic        outstanding[32];
  logic [31:0] arch[32];
  logic [31:0] rf[32];
  logic        pend_en;
  logic [4:0]  pend_rd;
  logic [31:0] pend_dat;

  logic [2:0]  t3_f3[4];
  logic [1:0]  t3_off[4];
  logic [31:0] t3_rdata[4];
  logic [31:0] t3_exp[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load value from the ISA definition: shift the lane to the top, then shift back down.
  function automatic logic [31:0] fmt(input logic [31:0] rdata, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic signed [31:0] s;
    int sh;
    case (f3)
      3'b000: begin sh = 8 * (3 - int'(off)); s = $signed(rdata << sh); return s >>> 24; end
      3'b100: begin sh = 8 * int'(off); return (rdata >> sh) & 32'hFF; end
      3'b001: begin sh = 16 * (1 - int'(off[1])); s = $signed(rdata << sh); return s >>> 16; end
      3'b101: begin sh = 16 * int'(off[1]); return (rdata >> sh) & 32'hFFFF; end
      default: return rdata;
    endcase
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return outstanding[a] || (!BYP && pend_en && pend_rd == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (BYP) return arch[a];
    return rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      outstanding[i] = 1'b0;
      arch[i] = 32'h0;
      rf[i] = 32'h0;
    end
    pend_en = 1'b0; pend_rd = 5'd0; pend_dat = 32'h0;
    exu_hold = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle();
    s_exu_v = 0; s_exu_rd = 0; s_exu_d = 0; s_iss = 0; s_iss_rd = 0;
    s_ret_v = 0; s_ret_rd = 0; s_ret_rdata = 0; s_ret_f3 = 3'b010; s_ret_off = 0;
    s_rs1 = 0; s_rs2 = 0;
  endtask

  task automatic drive();
    bus.wbu_i_exu_valid = s_exu_v;
    bus.wbu_i_exu_rd_addr = s_exu_rd;
    bus.wbu_i_exu_rd_data = s_exu_d;
    bus.wbu_i_lsu_issue = s_iss;
    bus.wbu_i_lsu_issue_rd_addr = s_iss_rd;
    bus.wbu_i_lsu_valid = s_ret_v;
    bus.wbu_i_lsu_rd_addr = s_ret_rd;
    bus.wbu_i_lsu_rdata = s_ret_rdata;
    bus.wbu_i_lsu_funct3 = s_ret_f3;
    bus.wbu_i_lsu_byte_off = s_ret_off;
    bus.wbu_i_rs1_addr = s_rs1;
    bus.wbu_i_rs2_addr = s_rs2;
    bus.wbu_i_rs1_data = rf[s_rs1];
    bus.wbu_i_rs2_data = rf[s_rs2];
  endtask

  // One clock: drive, check combinational outputs, predict the write, advance the model.
  task automatic cycle();
    logic        acc;
    logic [4:0]  ard;
    logic [31:0] adat;
    drive();
    #1;
    chk("exu_ready", 32'(bus.wbu_o_exu_ready), 32'(!s_ret_v));
    chk("lsu_ready", 32'(bus.wbu_o_lsu_ready), 32'd1);
    chk("rs1_busy", 32'(bus.wbu_o_rs1_busy), 32'(exp_busy(s_rs1)));
    chk("rs2_busy", 32'(bus.wbu_o_rs2_busy), 32'(exp_busy(s_rs2)));
    chk("rs1_data", bus.wbu_o_rs1_data, exp_data(s_rs1));
    chk("rs2_data", bus.wbu_o_rs2_data, exp_data(s_rs2));
    acc  = s_ret_v || s_exu_v;
    ard  = s_ret_v ? s_ret_rd : s_exu_rd;
    adat = s_ret_v ? fmt(s_ret_rdata, s_ret_f3, s_ret_off) : s_exu_d;
    if (acc && ard != 5'd0) exp_q.push_back('{ard, adat});
    @(posedge clk);
    if (pend_en) rf[pend_rd] = pend_dat;
    pend_en = acc && ard != 5'd0;
    pend_rd = ard;
    pend_dat = adat;
    if (pend_en) arch[ard] = adat;
    if (s_ret_v) outstanding[s_ret_rd] = 1'b0;
    if (s_iss && s_iss_rd != 5'd0) outstanding[s_iss_rd] = 1'b1;
    exu_hold = s_exu_v && s_ret_v;
    #1;
  endtask

  // Monitor: every write-port strobe must match the next predicted write.
  always @(negedge clk) begin
    if (!rst && bus.wbu_o_w_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got write rd=%0d data=%h, expected no write",
                 bus.wbu_o_rd_addr, bus.wbu_o_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 32'(bus.wbu_o_rd_addr), 32'(mon_e.rd));
        chk("wb_data", bus.wbu_o_rd_data, mon_e.data);
      end
    end
  end

  initial begin
    int olist[$];
    t3_f3 = '{3'b000, 3'b100, 3'b001, 3'b101};
    t3_off = '{2'd3, 2'd3, 2'd2, 2'd2};
    t3_rdata = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000, 32'h8001_0000};
    t3_exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};

    rst = 1'b0;
    idle();
    model_reset();
    drive();
    #2 rst = 1'b1;
    #1;
    chk("rst_wen", 32'(bus.wbu_o_w_en), 32'd0);
    chk("rst_addr", 32'(bus.wbu_o_rd_addr), 32'd0);
    chk("rst_data", bus.wbu_o_rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // EXU write with forwarding / stall
    idle(); s_exu_v = 1; s_exu_rd = 5; s_exu_d = 32'hDEAD_BEEF; s_rs1 = 5;
    cycle();
    chk("t1_wen", 32'(bus.wbu_o_w_en), 32'd1);
    chk("t1_addr", 32'(bus.wbu_o_rd_addr), 32'd5);
    chk("t1_data", bus.wbu_o_rd_data, 32'hDEAD_BEEF);
    idle(); s_rs1 = 5; drive(); #1;
    chk("t1_fwd", bus.wbu_o_rs1_data, BYP ? 32'hDEAD_BEEF : 32'h0);
    chk("t1_busy", 32'(bus.wbu_o_rs1_busy), BYP ? 32'd0 : 32'd1);
    cycle();

    // LSU beats EXU; EXU held and written next
    idle(); s_exu_v = 1; s_exu_rd = 3; s_exu_d = 32'h0000_3333;
    s_ret_v = 1; s_ret_rd = 4; s_ret_rdata = 32'h1234_5678; s_ret_f3 = 3'b010;
    cycle();
    chk("t2_lsu_addr", 32'(bus.wbu_o_rd_addr), 32'd4);
    chk("t2_lsu_data", bus.wbu_o_rd_data, 32'h1234_5678);
    s_ret_v = 0;
    cycle();
    chk("t2_exu_addr", 32'(bus.wbu_o_rd_addr), 32'd3);
    chk("t2_exu_data", bus.wbu_o_rd_data, 32'h0000_3333);

    // load formatting
    for (int i = 0; i < 4; i++) begin
      idle(); s_ret_v = 1; s_ret_rd = 10; s_ret_rdata = t3_rdata[i];
      s_ret_f3 = t3_f3[i]; s_ret_off = t3_off[i];
      cycle();
      chk("t3_fmt", bus.wbu_o_rd_data, t3_exp[i]);
    end

    // busy scoreboard on rd=7
    idle(); s_iss = 1; s_iss_rd = 7; s_rs2 = 7;
    cycle();
    idle(); s_rs2 = 7; drive(); #1;
    chk("t4_busy", 32'(bus.wbu_o_rs2_busy), 32'd1);
    cycle();
    idle(); s_ret_v = 1; s_ret_rd = 7; s_ret_rdata = 32'hAABB_CCDD; s_rs2 = 7;
    cycle();
    idle(); s_rs2 = 7; drive(); #1;
    chk("t4_busy_clr", 32'(bus.wbu_o_rs2_busy), BYP ? 32'd0 : 32'd1);
    chk("t4_data", bus.wbu_o_rs2_data, BYP ? 32'hAABB_CCDD : 32'h0);
    cycle();
    drive(); #1;
    chk("t4_busy_done", 32'(bus.wbu_o_rs2_busy), 32'd0);
    idle(); s_iss = 1; s_iss_rd = 0;
    cycle();
    idle(); drive(); #1;
    chk("t4_x0_busy", 32'(bus.wbu_o_rs2_busy), 32'd0);

    // write to x0
    idle(); s_exu_v = 1; s_exu_rd = 0; s_exu_d = 32'h1;
    cycle();
    chk("t5_wen", 32'(bus.wbu_o_w_en), 32'd0);
    idle();
    cycle();

    // asynchronous reset with a busy register and an active write stage
    idle(); s_iss = 1; s_iss_rd = 9;
    cycle();
    idle(); s_exu_v = 1; s_exu_rd = 12; s_exu_d = 32'h55;
    cycle();
    idle(); s_rs1 = 9; s_rs2 = 12; drive(); #1;
    chk("t6_pre_busy", 32'(bus.wbu_o_rs1_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(bus.wbu_o_rs1_busy), 32'd0);
    chk("t6_busy2", 32'(bus.wbu_o_rs2_busy), 32'd0);
    chk("t6_wen", 32'(bus.wbu_o_w_en), 32'd0);
    chk("t6_addr", 32'(bus.wbu_o_rd_addr), 32'd0);
    chk("t6_data", bus.wbu_o_rd_data, 32'd0);
    model_reset();
    idle(); drive();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    cycle();

    // randomized traffic
    repeat (3000) begin
      if (!exu_hold) begin
        s_exu_v = 1'($urandom_range(0, 1));
        s_exu_d = $urandom;
        s_exu_rd = 5'($urandom);
        for (int t = 0; t < 3; t++) if (outstanding[s_exu_rd]) s_exu_rd = 5'($urandom);
        if (outstanding[s_exu_rd]) s_exu_rd = 5'd0;
      end
      olist.delete();
      for (int r = 1; r < 32; r++) if (outstanding[r]) olist.push_back(r);
      s_ret_v = 1'b0; s_ret_rd = 5'd0;
      if (olist.size() > 0 && $urandom_range(0, 2) == 0) begin
        s_ret_v = 1'b1;
        s_ret_rd = 5'(olist[$urandom_range(0, olist.size() - 1)]);
      end else if ($urandom_range(0, 15) == 0) begin
        s_ret_v = 1'b1;
      end
      s_ret_rdata = $urandom;
      s_ret_f3 = 3'($urandom);
      s_ret_off = 2'($urandom);
      s_iss = ($urandom_range(0, 2) == 0);
      s_iss_rd = 5'($urandom);
      if (s_iss && outstanding[s_iss_rd] && !(s_ret_v && s_ret_rd == s_iss_rd)) s_iss = 1'b0;
      s_rs1 = ($urandom_range(0, 1) == 0) ? pend_rd : 5'($urandom);
      s_rs2 = ($urandom_range(0, 1) == 0) ? pend_rd : 5'($urandom);
      cycle();
    end

    idle();
    repeat (3) cycle();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
